// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front-end and the ALU it feeds.
// Holds opcode encodings and datapath widths; no ports.
package alu_pkg;

  localparam int ALU_DW = 8;  // operand width
  localparam int ALU_RW = 9;  // result width (bit 8 = carry / wrapped borrow)

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOP = 4'hF;

endpackage

// File: rtl/Sequential_ALU.sv
// Single-cycle registered ALU: Result is registered on the edge after the
// operands are presented. Unsupported opcodes produce 0.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   opcode, a, b operation and 8-bit operands
//   result       9-bit registered result
module Sequential_ALU
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        opcode,
  input  logic [ALU_DW-1:0] a,
  input  logic [ALU_DW-1:0] b,
  output logic [ALU_RW-1:0] result
);

  logic [ALU_RW-1:0] result_next;

  always_comb begin
    result_next = '0;
    case (opcode)
      OP_ADD:  result_next = {1'b0, a} + {1'b0, b};
      OP_SUB:  result_next = {1'b0, a} - {1'b0, b};
      OP_AND:  result_next = {1'b0, a & b};
      OP_OR:   result_next = {1'b0, a | b};
      OP_XOR:  result_next = {1'b0, a ^ b};
      default: result_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else begin
      result <= result_next;
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push, wdata     write request and data (ignored when full unless popping)
//   pop             read request (ignored when empty)
//   rdata           head entry (show-ahead)
//   full, empty     status
//   count           occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra bit: equal means empty, MSB-only difference means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so push on full is allowed then.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Command front-end for Sequential_ALU with tagged, credit-protected return path.
// Handshakes: a transfer occurs on any rising clk edge where valid && ready are
// both high; valid never depends on ready.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_opcode, cmd_a, cmd_b, cmd_tag command payload
//   alu_opcode, alu_a, alu_b         registered drive into the ALU
//   alu_result                       registered ALU result
//   rsp_valid/rsp_ready              response handshake
//   rsp_result, rsp_tag              response payload (FIFO head)
//   idle                             nothing queued or in flight
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_opcode,
  input  logic [ALU_DW-1:0] cmd_a,
  input  logic [ALU_DW-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [3:0]        alu_opcode,
  output logic [ALU_DW-1:0] alu_a,
  output logic [ALU_DW-1:0] alu_b,
  input  logic [ALU_RW-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ALU_RW-1:0] rsp_result,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              idle
);

  localparam int CMD_W  = 4 + 2 * ALU_DW + TAG_W;
  localparam int RSP_W  = ALU_RW + TAG_W;
  localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int RSP_CW = $clog2(RSP_DEPTH) + 1;
  localparam int SUM_W  = RSP_CW + 1;

  // Command FIFO
  logic              cmd_push;
  logic              cmd_pop;
  logic [CMD_W-1:0]  cmd_head;
  logic              cmd_full;
  logic              cmd_empty;
  logic [CMD_CW-1:0] cmd_count_unused;
  logic [3:0]        head_opcode;
  logic [ALU_DW-1:0] head_a;
  logic [ALU_DW-1:0] head_b;
  logic [TAG_W-1:0]  head_tag;

  // Response FIFO
  logic              rsp_push;
  logic              rsp_pop;
  logic [RSP_W-1:0]  rsp_head;
  logic              rsp_full;
  logic              rsp_empty;
  logic [RSP_CW-1:0] rsp_count;

  // Pipeline tracking of the ALU's one-cycle latency
  logic              s1_v;
  logic [TAG_W-1:0]  s1_tag;
  logic              s2_v;
  logic [TAG_W-1:0]  s2_tag;

  logic [SUM_W-1:0]  credit_used;
  logic              issue;

  // Ready looks only at full; a same-cycle pop does not open the door early.
  assign cmd_ready = !cmd_full;
  assign cmd_push  = cmd_valid && cmd_ready;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_push),
    .wdata ({cmd_opcode, cmd_a, cmd_b, cmd_tag}),
    .pop   (cmd_pop),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count_unused)
  );

  assign {head_opcode, head_a, head_b, head_tag} = cmd_head;

  // Every issued op reserves a response slot until it is popped: in-flight
  // stages plus stored results must stay below RSP_DEPTH, so the return-path
  // push can never meet a full FIFO.
  assign credit_used = SUM_W'(s1_v) + SUM_W'(s2_v) + SUM_W'(rsp_count);
  assign issue       = !cmd_empty && (credit_used < SUM_W'(RSP_DEPTH));
  assign cmd_pop     = issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= OP_NOP;
      alu_a      <= '0;
      alu_b      <= '0;
      s1_v       <= 1'b0;
      s1_tag     <= '0;
      s2_v       <= 1'b0;
      s2_tag     <= '0;
    end else begin
      if (issue) begin
        alu_opcode <= head_opcode;
        alu_a      <= head_a;
        alu_b      <= head_b;
        s1_v       <= 1'b1;
        s1_tag     <= head_tag;
      end else begin
        // Idle cycles feed a NOP; the ALU's zero output is never captured.
        alu_opcode <= OP_NOP;
        alu_a      <= '0;
        alu_b      <= '0;
        s1_v       <= 1'b0;
      end
      // The ALU registers its result on this same edge, so s2 lines up with it.
      s2_v   <= s1_v;
      s2_tag <= s1_tag;
      assert (!(s2_v && rsp_full && !rsp_pop));
    end
  end

  assign rsp_push = s2_v;
  assign rsp_pop  = rsp_valid && rsp_ready;

  sync_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_push),
    .wdata ({alu_result, s2_tag}),
    .pop   (rsp_pop),
    .rdata (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  assign rsp_valid             = !rsp_empty;
  assign {rsp_result, rsp_tag} = rsp_head;

  assign idle = cmd_empty && !s1_v && !s2_v && rsp_empty;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed and random bench for alu_issue_ctrl driving a Sequential_ALU.
module tb_alu_issue_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_tag;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [8:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [8:0] rsp_result;
  logic [3:0] rsp_tag;
  logic       idle;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_seen = 0;
  int pop_cyc[$];
  bit rand_ready = 0;
  logic [12:0] exp_q[$];

  alu_issue_ctrl #(
    .CMD_DEPTH (4),
    .RSP_DEPTH (4),
    .TAG_W     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_tag    (cmd_tag),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .idle       (idle)
  );

  Sequential_ALU u_alu (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (alu_opcode),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    case (op)
      4'h0:    r = 9'(a) + 9'(b);
      4'h1:    r = 9'(a) - 9'(b);
      4'h2:    r = 9'(a & b);
      4'h3:    r = 9'(a | b);
      4'h4:    r = 9'(a ^ b);
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each response on the cycle its handshake will complete.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      rsp_seen++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_tag), 32'hDEAD);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        check("rsp_result", 32'(rsp_result), 32'(e[12:4]));
        check("rsp_tag", 32'(rsp_tag), 32'(e[3:0]));
      end
    end
  end

  // Driver: hold the command until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
    int waited = 0;
    bit acc;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_tag    = tag;
    forever begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
      if (acc) begin
        exp_q.push_back({model(op, a, b), tag});
        break;
      end
      waited++;
      if (waited > 64) begin
        check("send_timeout", 32'(cmd_ready), 32'h1);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && idle) break;
      @(posedge clk);
      #1;
    end
    check(tag, 32'(idle && exp_q.size() == 0), 32'h1);
  endtask

  initial begin
    int base;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_opcode = 4'h0;
    cmd_a      = 8'h00;
    cmd_b      = 8'h00;
    cmd_tag    = 4'h0;
    rsp_ready  = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);

    // Reset state
    check("rst_alu_opcode", 32'(alu_opcode), 32'hF);
    check("rst_alu_a", 32'(alu_a), 32'h0);
    check("rst_alu_b", 32'(alu_b), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_result", 32'(rsp_result), 32'h0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check("rst_idle", 32'(idle), 32'h1);

    // Single ADD with carry: 200 + 100 = 0x12C, three-edge latency
    rsp_ready = 1'b1;
    send(4'h0, 8'd200, 8'd100, 4'd3);
    check("lat_e0", 32'(rsp_valid), 32'h0);
    step(1);
    check("lat_e1", 32'(rsp_valid), 32'h0);
    step(1);
    check("lat_e2", 32'(rsp_valid), 32'h0);
    step(1);
    check("lat_e3_valid", 32'(rsp_valid), 32'h1);
    check("lat_e3_result", 32'(rsp_result), 32'h12C);
    check("lat_e3_tag", 32'(rsp_tag), 32'h3);
    drain("single_idle");

    // Back-to-back stream, one result per cycle
    pop_cyc.delete();
    send(4'h1, 8'd5, 8'd10, 4'd0);
    send(4'h2, 8'hF0, 8'h3C, 4'd1);
    send(4'h3, 8'h0F, 8'hA0, 4'd2);
    send(4'h4, 8'hFF, 8'h0F, 4'd3);
    drain("stream_drain");
    check("stream_count", 32'(pop_cyc.size()), 32'd4);
    if (pop_cyc.size() == 4) check("stream_consecutive", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);

    // Backpressure: 8 ADDs, 4 held in response FIFO, 4 in command FIFO
    rsp_ready = 1'b0;
    base = rsp_seen;
    for (int i = 0; i < 8; i++) begin
      send(4'h0, 8'(i), 8'(i), 4'(i + 4));
    end
    step(5);
    check("bp_cmd_ready", 32'(cmd_ready), 32'h0);
    check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
    check("bp_idle", 32'(idle), 32'h0);
    check("bp_none_popped", 32'(rsp_seen - base), 32'd0);
    rsp_ready = 1'b1;
    drain("bp_drain");
    check("bp_all_returned", 32'(rsp_seen - base), 32'd8);

    // Unsupported opcode returns zero with its tag
    send(4'h7, 8'd1, 8'd1, 4'd9);
    drain("unsup_drain");

    // Reset mid-flight discards everything
    base = rsp_seen;
    send(4'h0, 8'd1, 8'd2, 4'd1);
    send(4'h0, 8'd3, 8'd4, 4'd2);
    send(4'h0, 8'd5, 8'd6, 4'd3);
    send(4'h0, 8'd7, 8'd8, 4'd4);
    rst_n = 1'b0;
    exp_q.delete();
    step(1);
    rst_n = 1'b1;
    check("mid_rst_alu_opcode", 32'(alu_opcode), 32'hF);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check("mid_rst_idle", 32'(idle), 32'h1);
    step(6);
    check("mid_rst_no_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_no_rsp", 32'(rsp_seen - base), 32'd0);
    check("mid_rst_idle_after", 32'(idle), 32'h1);

    // Pointer wrap: random commands with random response backpressure
    base = rsp_seen;
    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'(i));
    end
    rand_ready = 1'b0;
    rsp_ready = 1'b1;
    drain("wrap_drain");
    check("wrap_count", 32'(rsp_seen - base), 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
